// File: rtl/truxton2_scr_fetch_if.sv
// Signal bundle between a GP9001 scroll-layer fetcher and its tilemap VRAM,
// 32-bit GFX ROM slot and line buffer. master = fetcher, slave = environment.
interface truxton2_scr_fetch_if;
  localparam int unsigned YW  = 9;
  localparam int unsigned VAW = 10;
  localparam int unsigned GAW = 22;
  localparam int unsigned LAW = 9;
  localparam int unsigned LDW = 10;

  logic           LINE_START;
  logic [YW-1:0]  LINE_Y;
  logic [YW-1:0]  XSCROLL;
  logic [VAW-1:0] VRAM_ADDR;
  logic [15:0]    VRAM_CODE;
  logic [7:0]     VRAM_ATTR;
  logic           GFX_CS;
  logic [GAW-1:0] GFX_ADDR;
  logic [31:0]    GFX_DOUT;
  logic           GFX_OK;
  logic           LB_WE;
  logic [LAW-1:0] LB_ADDR;
  logic [LDW-1:0] LB_DATA;
  logic           BUSY;
  logic           DONE;

  modport master (
    input  LINE_START, LINE_Y, XSCROLL, VRAM_CODE, VRAM_ATTR, GFX_DOUT, GFX_OK,
    output VRAM_ADDR, GFX_CS, GFX_ADDR, LB_WE, LB_ADDR, LB_DATA, BUSY, DONE
  );

  modport slave (
    output LINE_START, LINE_Y, XSCROLL, VRAM_CODE, VRAM_ATTR, GFX_DOUT, GFX_OK,
    input  VRAM_ADDR, GFX_CS, GFX_ADDR, LB_WE, LB_ADDR, LB_DATA, BUSY, DONE
  );
endinterface

// File: rtl/truxton2_scr_fetch.sv
// Per-line tile fetcher for one GP9001 scroll layer: tilemap lookup, 4bpp ROM
// row fetch through one GFX slot, and pixel unpack into the layer line buffer.
module truxton2_scr_fetch #(
  parameter int unsigned WIDTH  = 320,
  parameter int unsigned TILES  = 21,
  parameter int unsigned GFX_AW = 22
) (
  input  logic                CLK,
  input  logic                RESET_N,
  truxton2_scr_fetch_if.master bus
);

  localparam int unsigned TW = 5;
  localparam int unsigned XW = 10;

  typedef enum logic [2:0] {
    S_IDLE, S_MAP, S_MAPW, S_REQ, S_DRAW, S_FIN
  } state_e;

  state_e        state_q, state_d;
  logic [TW-1:0] t_q, t_d;
  logic          h_q, h_d;
  logic [2:0]    i_q, i_d;
  logic [8:0]    y_q, y_d;
  logic [8:0]    xs_q, xs_d;
  logic [15:0]   code_q, code_d;
  logic [7:0]    attr_q, attr_d;
  logic [3:0]    frow_q, frow_d;
  logic [31:0]   data_q, data_d;
  logic          first_q, first_d;

  logic [9:0]        vaddr_q, vaddr_d;
  logic              cs_q, cs_d;
  logic [GFX_AW-1:0] gaddr_q, gaddr_d;
  logic              we_q, we_d;
  logic [8:0]        lbaddr_q, lbaddr_d;
  logic [9:0]        lbdata_q, lbdata_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;

  function automatic logic [9:0] map_addr(input logic [8:0] y, input logic [8:0] xs,
                                          input logic [TW-1:0] t);
    return {y[8:4], 5'(xs[8:4] + t)};
  endfunction

  function automatic logic [GFX_AW-1:0] gfx_addr(input logic [15:0] code,
                                                 input logic [3:0] frow, input logic hsel);
    return GFX_AW'({code, frow, hsel, 1'b0});
  endfunction

  logic [TW-1:0] t_inc;
  logic [3:0]    frow_n;
  assign t_inc  = t_q + TW'(1);
  assign frow_n = bus.VRAM_ATTR[7] ? ~y_q[3:0] : y_q[3:0];

  // Pixel for the draw slot about to be presented: slot 0 straight from ROM on capture
  logic [2:0]    pix_i;
  logic [31:0]   pix_word;
  logic [2:0]    pix_n;
  logic [3:0]    pix_val;
  logic [XW-1:0] pix_x;
  logic          pix_we;

  always_comb begin
    pix_i    = (state_q == S_REQ) ? 3'd0 : i_q + 3'd1;
    pix_word = (state_q == S_REQ) ? bus.GFX_DOUT : data_q;
    pix_n    = attr_q[6] ? ~pix_i : pix_i;
    pix_val  = 4'(pix_word >> (5'd28 - {pix_n, 2'b00}));
    pix_x    = XW'({t_q, 4'b0000}) + XW'({h_q, 3'b000}) + XW'(pix_i) - XW'(xs_q[3:0]);
    pix_we   = (pix_val != 4'd0) && !pix_x[XW-1] && (pix_x < XW'(WIDTH));
  end

  // Next-state and registered-output logic
  always_comb begin
    state_d  = state_q;
    t_d      = t_q;
    h_d      = h_q;
    i_d      = i_q;
    y_d      = y_q;
    xs_d     = xs_q;
    code_d   = code_q;
    attr_d   = attr_q;
    frow_d   = frow_q;
    data_d   = data_q;
    first_d  = first_q;
    vaddr_d  = vaddr_q;
    cs_d     = cs_q;
    gaddr_d  = gaddr_q;
    we_d     = 1'b0;
    lbaddr_d = lbaddr_q;
    lbdata_d = lbdata_q;
    busy_d   = busy_q;
    done_d   = 1'b0;

    case (state_q)
      S_IDLE: ;
      S_MAP: state_d = S_MAPW;
      S_MAPW: begin
        code_d  = bus.VRAM_CODE;
        attr_d  = bus.VRAM_ATTR;
        frow_d  = frow_n;
        h_d     = 1'b0;
        cs_d    = 1'b1;
        first_d = 1'b1;
        gaddr_d = gfx_addr(bus.VRAM_CODE, frow_n, bus.VRAM_ATTR[6]);
        state_d = S_REQ;
      end
      S_REQ: begin
        first_d = 1'b0;
        // An OK seen in the first CS cycle may belong to the previous address
        if (!first_q && bus.GFX_OK) begin
          data_d   = bus.GFX_DOUT;
          cs_d     = 1'b0;
          i_d      = 3'd0;
          we_d     = pix_we;
          lbaddr_d = pix_x[8:0];
          lbdata_d = {attr_q[5:0], pix_val};
          state_d  = S_DRAW;
        end
      end
      S_DRAW: begin
        if (i_q != 3'd7) begin
          i_d      = i_q + 3'd1;
          we_d     = pix_we;
          lbaddr_d = pix_x[8:0];
          lbdata_d = {attr_q[5:0], pix_val};
        end else if (!h_q) begin
          h_d     = 1'b1;
          cs_d    = 1'b1;
          first_d = 1'b1;
          gaddr_d = gfx_addr(code_q, frow_q, ~attr_q[6]);
          state_d = S_REQ;
        end else begin
          t_d = t_inc;
          h_d = 1'b0;
          if (t_inc == TW'(TILES)) begin
            busy_d  = 1'b0;
            done_d  = 1'b1;
            state_d = S_FIN;
          end else begin
            vaddr_d = map_addr(y_q, xs_q, t_inc);
            state_d = S_MAP;
          end
        end
      end
      S_FIN: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    // A new line start wins everywhere; an in-flight line is dropped without DONE
    if (bus.LINE_START) begin
      y_d     = bus.LINE_Y;
      xs_d    = bus.XSCROLL;
      t_d     = '0;
      h_d     = 1'b0;
      busy_d  = 1'b1;
      cs_d    = 1'b0;
      we_d    = 1'b0;
      done_d  = 1'b0;
      vaddr_d = map_addr(bus.LINE_Y, bus.XSCROLL, '0);
      state_d = S_MAP;
    end
  end

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      state_q  <= S_IDLE;
      t_q      <= '0;
      h_q      <= 1'b0;
      i_q      <= '0;
      y_q      <= '0;
      xs_q     <= '0;
      code_q   <= '0;
      attr_q   <= '0;
      frow_q   <= '0;
      data_q   <= '0;
      first_q  <= 1'b0;
      vaddr_q  <= '0;
      cs_q     <= 1'b0;
      gaddr_q  <= '0;
      we_q     <= 1'b0;
      lbaddr_q <= '0;
      lbdata_q <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      t_q      <= t_d;
      h_q      <= h_d;
      i_q      <= i_d;
      y_q      <= y_d;
      xs_q     <= xs_d;
      code_q   <= code_d;
      attr_q   <= attr_d;
      frow_q   <= frow_d;
      data_q   <= data_d;
      first_q  <= first_d;
      vaddr_q  <= vaddr_d;
      cs_q     <= cs_d;
      gaddr_q  <= gaddr_d;
      we_q     <= we_d;
      lbaddr_q <= lbaddr_d;
      lbdata_q <= lbdata_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
    end
  end

  assign bus.VRAM_ADDR = vaddr_q;
  assign bus.GFX_CS    = cs_q;
  assign bus.GFX_ADDR  = gaddr_q;
  assign bus.LB_WE     = we_q;
  assign bus.LB_ADDR   = lbaddr_q;
  assign bus.LB_DATA   = lbdata_q;
  assign bus.BUSY      = busy_q;
  assign bus.DONE      = done_q;

endmodule

// File: tb/tb_truxton2_scr_fetch.sv
// Directed bench for truxton2_scr_fetch: sync VRAM model, delayed-OK GFX slot
// model and a line-buffer write recorder, checked against hand-derived values.
module tb_truxton2_scr_fetch;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;

  truxton2_scr_fetch_if bus();

  truxton2_scr_fetch dut (
    .CLK     (clk),
    .RESET_N (rst_n),
    .bus     (bus)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_bad = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Environment configuration
  logic [15:0] cfg_code  = 16'h0001;
  logic        code_by_col = 1'b0;
  logic [7:0]  cfg_attr  = 8'h00;
  logic [31:0] rom_word  = 32'h1234_5678;
  int          ok_delay  = 3;
  logic        stale_mode = 1'b0;

  // Tilemap VRAM: synchronous read, one cycle latency
  always @(posedge clk) begin
    bus.VRAM_CODE <= code_by_col ? 16'(bus.VRAM_ADDR[4:0]) + 16'd1 : cfg_code;
    bus.VRAM_ATTR <= cfg_attr;
  end

  // GFX slot: OK after ok_delay cycles of a stable request; stale mode holds OK
  // high and shows junk data in the first cycle of every new address
  logic        prev_cs   = 1'b0;
  logic [21:0] prev_addr = '0;
  int          rom_cnt   = 0;
  logic        rom_first;
  int          rom_idx;

  always_comb begin
    rom_first    = bus.GFX_CS && !(prev_cs && bus.GFX_ADDR == prev_addr);
    rom_idx      = rom_first ? 0 : rom_cnt;
    bus.GFX_OK   = stale_mode ? 1'b1 : (bus.GFX_CS && rom_idx >= ok_delay);
    bus.GFX_DOUT = (stale_mode && rom_idx == 0) ? 32'hFFFF_FFFF : rom_word;
  end

  always @(posedge clk) begin
    prev_cs   <= bus.GFX_CS;
    prev_addr <= bus.GFX_ADDR;
    rom_cnt   <= bus.GFX_CS ? rom_idx + 1 : 0;
  end

  // Recorders
  logic [8:0]  wr_x[$];
  logic [9:0]  wr_d[$];
  logic [21:0] gfx_q[$];
  int          done_cnt = 0;
  int          oob_cnt  = 0;
  logic        mon_cs   = 1'b0;
  logic [21:0] mon_addr = '0;

  always @(negedge clk) begin
    if (rst_n) begin
      if (bus.LB_WE) begin
        wr_x.push_back(bus.LB_ADDR);
        wr_d.push_back(bus.LB_DATA);
        if (bus.LB_ADDR >= 9'd320) oob_cnt++;
      end
      if (bus.DONE) done_cnt++;
      if (bus.GFX_CS && !(mon_cs && bus.GFX_ADDR == mon_addr)) gfx_q.push_back(bus.GFX_ADDR);
    end
    mon_cs   = bus.GFX_CS;
    mon_addr = bus.GFX_ADDR;
  end

  task automatic clear_rec();
    wr_x.delete();
    wr_d.delete();
    gfx_q.delete();
    done_cnt = 0;
    oob_cnt  = 0;
  endtask

  task automatic start_line(input logic [8:0] y, input logic [8:0] xs);
    @(negedge clk);
    bus.LINE_Y     = y;
    bus.XSCROLL    = xs;
    bus.LINE_START = 1'b1;
    @(negedge clk);
    bus.LINE_START = 1'b0;
  endtask

  task automatic wait_done(input string tag, input int budget);
    int n;
    n = 0;
    while (done_cnt == 0 && n < budget) begin
      @(negedge clk);
      n++;
    end
    repeat (8) @(negedge clk);
    chk({tag, "_done"}, 32'(done_cnt), 32'd1);
    chk({tag, "_busy"}, 32'(bus.BUSY), 32'd0);
  endtask

  // mode 0: pixel (x%8)+1; 1: fine scroll 3; 2: flipped, pal 5; 3: sparse word
  task automatic check_line(input string tag, input int mode, input int exp_cnt);
    int errs;
    int ex;
    int ed;
    errs = 0;
    chk({tag, "_cnt"}, 32'(wr_x.size()), 32'(exp_cnt));
    chk({tag, "_oob"}, 32'(oob_cnt), 32'd0);
    foreach (wr_x[k]) begin
      ex = k;
      case (mode)
        0: ed = (k % 8) + 1;
        1: ed = ((k + 3) % 8) + 1;
        2: ed = 32'h50 | (8 - (k % 8));
        default: begin
          ex = (k / 2) * 8 + (k % 2) * 7;
          ed = 1;
        end
      endcase
      if (int'(wr_x[k]) != ex || int'(wr_d[k]) != ed) errs++;
    end
    chk({tag, "_pix"}, 32'(errs), 32'd0);
  endtask

  initial begin
    int n;
    bus.LINE_START = 1'b0;
    bus.LINE_Y     = '0;
    bus.XSCROLL    = '0;

    // Reset state
    #12;
    chk("rst_cs",    32'(bus.GFX_CS),    32'd0);
    chk("rst_we",    32'(bus.LB_WE),     32'd0);
    chk("rst_busy",  32'(bus.BUSY),      32'd0);
    chk("rst_done",  32'(bus.DONE),      32'd0);
    chk("rst_vaddr", 32'(bus.VRAM_ADDR), 32'd0);
    chk("rst_gaddr", 32'(bus.GFX_ADDR),  32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // T1: plain line, codes 1, word 12345678, 3-cycle OK delay
    clear_rec();
    start_line(9'd0, 9'd0);
    chk("t1_busy_up", 32'(bus.BUSY), 32'd1);
    wait_done("t1", 3000);
    check_line("t1", 0, 320);
    chk("t1_ga0",  32'(gfx_q.size() > 1 ? gfx_q[0] : 22'h3FFFFF), 32'h40);
    chk("t1_ga1",  32'(gfx_q.size() > 1 ? gfx_q[1] : 22'h3FFFFF), 32'h42);
    chk("t1_nreq", 32'(gfx_q.size()), 32'd42);

    // T2: XSCROLL 1F3, code = col+1 so the column order shows in GFX_ADDR
    clear_rec();
    code_by_col = 1'b1;
    start_line(9'd0, 9'h1F3);
    wait_done("t2", 3000);
    check_line("t2", 1, 320);
    if (gfx_q.size() > 2) begin
      chk("t2_ga_col31", 32'(gfx_q[0]), 32'h800);
      chk("t2_ga_col31h", 32'(gfx_q[1]), 32'h802);
      chk("t2_ga_col0",  32'(gfx_q[2]), 32'h040);
    end else chk("t2_nreq", 32'(gfx_q.size()), 32'd42);
    if (wr_x.size() > 0) chk("t2_first", {22'd0, wr_d[0]}, 32'h4);
    code_by_col = 1'b0;

    // T3: flipx+flipy, code 2, LINE_Y 1, pal 5
    clear_rec();
    cfg_code = 16'h0002;
    cfg_attr = 8'hC5;
    start_line(9'd1, 9'd0);
    wait_done("t3", 3000);
    check_line("t3", 2, 320);
    if (gfx_q.size() > 1) begin
      chk("t3_ga0", 32'(gfx_q[0]), 32'hBA);
      chk("t3_ga1", 32'(gfx_q[1]), 32'hB8);
    end else chk("t3_nreq", 32'(gfx_q.size()), 32'd42);
    cfg_code = 16'h0001;
    cfg_attr = 8'h00;

    // T4: sparse word, transparent nibbles never written
    clear_rec();
    rom_word = 32'h1000_0001;
    start_line(9'd0, 9'd0);
    wait_done("t4", 3000);
    check_line("t4", 3, 80);
    rom_word = 32'h1234_5678;

    // T5: OK stuck high across address changes
    clear_rec();
    stale_mode = 1'b1;
    start_line(9'd0, 9'd0);
    wait_done("t5", 3000);
    check_line("t5", 0, 320);
    stale_mode = 1'b0;

    // T6: restart in the middle of a long REQ
    clear_rec();
    ok_delay = 20;
    start_line(9'h010, 9'd0);
    n = 0;
    while (!bus.GFX_CS && n < 200) begin
      @(negedge clk);
      n++;
    end
    chk("t6_cs_up", 32'(bus.GFX_CS), 32'd1);
    repeat (2) @(negedge clk);
    bus.LINE_Y     = 9'd0;
    bus.XSCROLL    = 9'd0;
    bus.LINE_START = 1'b1;
    @(negedge clk);
    bus.LINE_START = 1'b0;
    ok_delay = 3;
    chk("t6_cs_drop", 32'(bus.GFX_CS), 32'd0);
    chk("t6_busy",    32'(bus.BUSY),   32'd1);
    chk("t6_no_done", 32'(done_cnt),   32'd0);
    wr_x.delete();
    wr_d.delete();
    wait_done("t6", 3000);
    repeat (30) @(negedge clk);
    chk("t6_one_done", 32'(done_cnt), 32'd1);
    check_line("t6", 0, 320);

    // T7: asynchronous reset in the middle of DRAW
    clear_rec();
    start_line(9'd0, 9'd0);
    n = 0;
    while (!bus.LB_WE && n < 200) begin
      @(negedge clk);
      n++;
    end
    chk("t7_in_draw", 32'(bus.LB_WE), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("t7_we",     32'(bus.LB_WE),     32'd0);
    chk("t7_busy",   32'(bus.BUSY),      32'd0);
    chk("t7_cs",     32'(bus.GFX_CS),    32'd0);
    chk("t7_laddr",  32'(bus.LB_ADDR),   32'd0);
    chk("t7_ldata",  32'(bus.LB_DATA),   32'd0);
    chk("t7_vaddr",  32'(bus.VRAM_ADDR), 32'd0);
    chk("t7_gaddr",  32'(bus.GFX_ADDR),  32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    chk("t7_idle", 32'(bus.BUSY), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached, vectors %0d", n_vec);
    $fatal(1);
  end

endmodule

// File: doc/truxton2_scr_fetch.md
Name: truxton2_scr_fetch

Overview:
- Per-line tile fetcher for one GP9001 scroll layer.
- On each line it reads tilemap entries from the layer VRAM and requests 4bpp tile row data through one 32-bit GFX slot of the bank-1 SDRAM ROM arbiter (e.g. GFXSCR0).
- It unpacks that data into pixels and writes them into the layer's line buffer.
- It is the direct downstream consumer of the GFXSCRx_CS/ADDR/DOUT/OK ports.

Parameters:
- WIDTH, 320, visible pixels per line; line-buffer writes are limited to x < WIDTH.
- TILES, 21, tiles fetched per line (WIDTH/16 + 1 for fine scroll).
- GFX_AW, 22, GFX address width (16-bit word addressing).

Ports:
- CLK  in  1  core clock.
- RESET_N  in  1  asynchronous, active-low reset.
- LINE_START  in  1  one-cycle pulse that starts a line fetch.
- LINE_Y  in  9  line number with vertical scroll already added.
- XSCROLL  in  9  horizontal scroll.
- VRAM_ADDR  out  10  tilemap index {row[4:0], col[4:0]}.
- VRAM_CODE  in  16  tile code; sync RAM, valid 1 cycle after VRAM_ADDR.
- VRAM_ATTR  in  8  {flipy, flipx, pal[5:0]}; same timing as VRAM_CODE.
- GFX_CS  out  1  ROM request.
- GFX_ADDR  out  22  ROM word address.
- GFX_DOUT  in  32  ROM data.
- GFX_OK  in  1  ROM data valid for the current GFX_ADDR.
- LB_WE  out  1  line-buffer write strobe.
- LB_ADDR  out  9  line-buffer x.
- LB_DATA  out  10  {pal[5:0], pixel[3:0]}.
- BUSY  out  1  fetch in progress.
- DONE  out  1  one-cycle pulse when the line is complete.

Behaviour:
- Reset (asynchronous, RESET_N=0):
  - state=IDLE.
  - GFX_CS, LB_WE, BUSY, DONE = 0.
  - VRAM_ADDR, GFX_ADDR, LB_ADDR, LB_DATA = 0.
  - Internal tile counter t=0.
- Latches at LINE_START: LINE_Y and XSCROLL. Tile row r=LINE_Y[8:4], fine row fy=LINE_Y[3:0].
- Per tile t (0..TILES-1):
  - col = (XSCROLL[8:4]+t) mod 32, 5-bit wrap.
  - VRAM_ADDR = {r, col}.
- States:
  - IDLE: wait for LINE_START; then BUSY=1, t=0, go to MAP.
  - MAP: drive VRAM_ADDR. Next cycle (MAPW) latch code and attr.
    - frow = flipy ? 15-fy : fy.
    - Go to REQ with half h=0.
  - REQ: GFX_CS=1, GFX_ADDR = {code, frow[3:0], hsel, 1'b0}, 22 bits, hsel = h XOR flipx.
    - GFX_ADDR is held stable while CS=1.
    - GFX_OK is ignored in the first CS cycle (stale-OK guard).
    - The first later cycle with CS&&OK latches GFX_DOUT. CS drops the next cycle; go to DRAW.
    - No timeout; the state waits indefinitely.
  - DRAW: 8 cycles, i=0..7.
    - Nibble n = flipx ? 7-i : i. Pixel = GFX_DOUT[31-4n -: 4], i.e. pixel 0 is the MSB nibble.
    - x = t*16 + h*8 + i - XSCROLL[3:0], 10-bit signed arithmetic.
    - LB_WE=1 only if pixel≠0 and 0≤x<WIDTH. LB_ADDR=x[8:0], LB_DATA={pal, pixel}.
    - After i=7: if h=0, set h=1 and go to REQ; else t++. If t==TILES go to FIN, else go to MAP.
  - FIN: DONE=1 for one cycle, BUSY=0, go to IDLE.
- Min latency per tile: 2 (map) + 2×(2 req + SDRAM wait + 8 draw) cycles.
- LINE_START while BUSY: abort the current line and restart at MAP with the new latches next cycle. GFX_CS deasserts for ≥1 cycle first; no DONE is issued for the aborted line.
- LINE_START coincident with FIN: FIN's DONE still pulses, then the restart proceeds.
- No line-buffer writes outside DRAW. Transparent pixel 0 is never written (buffer clearing is external).

Test Plan:
- Reset, LINE_Y=0, XSCROLL=0, all codes=1, attr=0, ROM word = 32'h12345678, 3-cycle OK delay → LB writes x=0..319 with pixel sequence 1,2,...,8 repeating, pal=0. DONE arrives once, BUSY then falls, and there is no write at x≥320.
- XSCROLL=9'h1F3 → first tile col=31; writes start at x=0 with that tile's nibble 3. col wraps to 0 for t=1.
- attr flipx=1, flipy=1, code=16'h0002, LINE_Y=1 → GFX_ADDR sequence 22'h0000BA then 22'h0000B8. Pixels within each word run nibble 7 down to 0.
- ROM word 32'h10000001 → writes only at relative x=0 and 7, nothing for the zero nibbles.
- OK held high while the address changes (stale OK) → data is not captured in the first CS cycle; the capture happens only after the second-cycle OK.
- LINE_START mid-REQ: CS drops, no DONE for the first line, and the new line completes with its own DONE. RESET_N low mid-DRAW → all outputs 0 immediately.
